// File: rtl/uart_tx_if.sv
// Parallel-side and line-side signals of the UART transmitter.
// The master drives the word and frame options; the slave (transmitter)
// drives the serial line and the busy flag.
interface uart_tx_if #(
    parameter int DATA_LENGTH = 8
);
    logic [DATA_LENGTH-1:0] P_DATA;
    logic                   DATA_VALID;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic                   TX_OUT;
    logic                   Busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_top.sv
// UART transmitter: one bit per baud clock. A frame is made of a start bit,
// DATA_LENGTH data bits sent LSB first, an optional parity bit and a stop bit.
// A new word may be accepted in the stop cycle, so back-to-back frames leave
// no idle gap on the line.
module uart_tx_top #(
    parameter int DATA_LENGTH = 8
) (
    input  logic      CLK_TX,
    input  logic      RST_TX,
    uart_tx_if.slave  tx_if
);
    localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_LENGTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   accept;

    // Next-state, datapath and registered line value for the upcoming cycle.
    // shift_q[0] always holds the next data bit to be put on the line; it is
    // consumed (shifted out) on every edge that lands in DATA.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        accept    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_if.DATA_VALID) begin
                    accept = 1'b1;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                if (tx_if.DATA_VALID) begin
                    accept = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Capture word and frame options so later input changes cannot
        // disturb the frame in flight.
        if (accept) begin
            state_d   = S_START;
            shift_d   = tx_if.P_DATA;
            par_en_d  = tx_if.PAR_EN;
            par_bit_d = tx_if.PAR_TYP ? ~^tx_if.P_DATA : ^tx_if.P_DATA;
        end

        if (state_d == S_DATA) begin
            shift_d = shift_q >> 1;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge CLK_TX or posedge RST_TX) begin
        if (RST_TX) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top (DATA_LENGTH = 8). Expected line sequences
// are written MSB-first: bit [10] is the first cycle after the accept edge.
module tb_uart_tx_top;
    logic CLK_TX = 1'b0;
    logic RST_TX = 1'b1;

    int checks   = 0;
    int failures = 0;

    uart_tx_if #(.DATA_LENGTH(8)) tx_if ();

    uart_tx_top #(.DATA_LENGTH(8)) dut (
        .CLK_TX (CLK_TX),
        .RST_TX (RST_TX),
        .tx_if  (tx_if)
    );

    always #5 CLK_TX = ~CLK_TX;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [10:0] exp_seq;
        int          len;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK_TX);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent frame builder for the randomised section.
    function automatic logic [10:0] build_seq(input logic [7:0] d, input logic pe, input logic pt);
        logic [10:0] s;
        s[10] = 1'b0;
        for (int i = 0; i < 8; i++) s[9-i] = d[i];
        if (pe) begin
            s[1] = pt ? ~^d : ^d;
            s[0] = 1'b1;
        end else begin
            s[1] = 1'b1;
            s[0] = 1'b0;
        end
        return s;
    endfunction

    // Send one word with a single-cycle request and check every line cycle,
    // then the return to idle.
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [10:0] exp, input int len);
        int bad;
        bad = failures;
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pe;
        tx_if.PAR_TYP    = pt;
        tx_if.DATA_VALID = 1'b1;
        tick();
        tx_if.DATA_VALID = 1'b0;
        tx_if.P_DATA     = ~d;
        tx_if.PAR_EN     = ~pe;
        tx_if.PAR_TYP    = ~pt;
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            chk($sformatf("%s cyc%0d {tx,busy}", name, i),
                {30'd0, tx_if.TX_OUT, tx_if.Busy}, {30'd0, exp[10-i], 1'b1});
        end
        tick();
        chk($sformatf("%s idle {tx,busy}", name),
            {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd2);
        $display("frame %s data=%02h par_en=%0b par_typ=%0b len=%0d errors=%0d",
                 name, d, pe, pt, len, failures - bad);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 11};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 11'b01010010111, 11};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 11'b01010010110, 10};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 11'b00000000001, 11};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 11'b01000000001, 11};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 11'b01111111110, 10};

        tx_if.P_DATA     = 8'h00;
        tx_if.DATA_VALID = 1'b0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;

        // Reset held for two cycles, then five idle cycles.
        RST_TX = 1'b1;
        tick();
        chk("reset tx", {31'd0, tx_if.TX_OUT}, 32'd1);
        chk("reset busy", {31'd0, tx_if.Busy}, 32'd0);
        tick();
        RST_TX = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle {tx,busy}", {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd2);
        end
        $display("reset/idle sequence done");

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].par_en,
                      vecs[v].par_typ, vecs[v].exp_seq, vecs[v].len);
        end

        // Back-to-back: 0x55 then 0xAA with DATA_VALID held, even parity.
        begin
            logic [21:0] exp_b2b;
            exp_b2b = {11'b01010101001, 11'b00101010101};
            tx_if.P_DATA     = 8'h55;
            tx_if.PAR_EN     = 1'b1;
            tx_if.PAR_TYP    = 1'b0;
            tx_if.DATA_VALID = 1'b1;
            for (int i = 0; i < 22; i++) begin
                tick();
                if (i == 10) tx_if.P_DATA = 8'hAA;
                if (i == 11) tx_if.DATA_VALID = 1'b0;
                chk($sformatf("b2b cyc%0d {tx,busy}", i),
                    {30'd0, tx_if.TX_OUT, tx_if.Busy}, {30'd0, exp_b2b[21-i], 1'b1});
            end
            tick();
            chk("b2b idle {tx,busy}", {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd2);
            $display("frame b2b data=55,aa");
        end

        // Request during DATA is ignored: 0x00 frame unchanged, no second frame.
        begin
            logic [10:0] exp_z;
            exp_z = 11'b00000000001;
            tx_if.P_DATA     = 8'h00;
            tx_if.PAR_EN     = 1'b1;
            tx_if.PAR_TYP    = 1'b0;
            tx_if.DATA_VALID = 1'b1;
            tick();
            tx_if.DATA_VALID = 1'b0;
            for (int i = 0; i < 11; i++) begin
                if (i > 0) tick();
                if (i == 3) begin
                    tx_if.P_DATA     = 8'hFF;
                    tx_if.DATA_VALID = 1'b1;
                end
                if (i == 4) tx_if.DATA_VALID = 1'b0;
                chk($sformatf("ignore cyc%0d {tx,busy}", i),
                    {30'd0, tx_if.TX_OUT, tx_if.Busy}, {30'd0, exp_z[10-i], 1'b1});
            end
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("ignore idle {tx,busy}", {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd2);
            end
            $display("frame ignore data=00 (ff request dropped)");
        end

        // Asynchronous reset during the start bit.
        tx_if.P_DATA     = 8'hA5;
        tx_if.PAR_EN     = 1'b1;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.DATA_VALID = 1'b1;
        tick();
        tx_if.DATA_VALID = 1'b0;
        chk("async pre {tx,busy}", {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd1);
        #3;
        RST_TX = 1'b1;
        #1;
        chk("async rst {tx,busy}", {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd2);
        tick();
        RST_TX = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post rst idle {tx,busy}", {30'd0, tx_if.TX_OUT, tx_if.Busy}, 32'd2);
        end
        $display("async reset mid-frame done");

        // Random words across all parity settings.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic       pe, pt;
            d  = 8'($urandom_range(0, 255));
            pe = n[0];
            pt = n[1];
            run_frame($sformatf("rnd%0d", n), d, pe, pt, build_seq(d, pe, pt), pe ? 11 : 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

UART transmitter that serializes one parallel word into an asynchronous frame: start bit, data bits LSB first, optional parity bit, stop bit. It is the upstream stage of the UART receive path: its TX_OUT drives the receiver's RX_IN line. It runs on the baud-rate clock (115.2 kHz in the system bench), so each bit occupies exactly one clock cycle. Frame format and parity conventions match the receiver so that loopback benches can pair the two directly.

## Interface
- DATA_LENGTH, 8, number of data bits per frame (legal range 5–9)
- CLK_TX  input  1  baud-rate clock; all logic on rising edge
- RST_TX  input  1  reset, asynchronous, active-high
- P_DATA  input  DATA_LENGTH  parallel word to transmit
- DATA_VALID  input  1  request to send P_DATA; sampled on rising edge
- PAR_EN  input  1  1 = parity bit inserted after data
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- TX_OUT  output  1  serial line, registered; idles high
- Busy  output  1  registered; high while a frame is on the line

## Operation
- States: IDLE, START, DATA, PARITY, STOP (3-bit encoding, free choice).
- Accept: DATA_VALID=1 sampled in IDLE, or in STOP.
  - On accept, latch P_DATA into the shift register.
  - On accept, latch PAR_EN and PAR_TYP, and latch the parity bit:
    - even parity bit = ^P_DATA
    - odd parity bit = ~^P_DATA
  - Inputs may change after the accept edge without affecting the frame in flight.
- IDLE → START on accept. Otherwise stay in IDLE with TX_OUT=1.
- START: TX_OUT=0 for one cycle, then → DATA.
- DATA: TX_OUT = shift_reg[0]. The shift register moves right each cycle. A bit counter (width ≥ clog2(DATA_LENGTH)) runs 0..DATA_LENGTH-1.
  - When counter = DATA_LENGTH-1: → PARITY if latched PAR_EN=1, else → STOP.
  - The counter clears on leaving DATA.
- PARITY: TX_OUT = latched parity bit for one cycle, then → STOP.
- STOP: TX_OUT=1 for one cycle.
  - DATA_VALID=1 at the STOP edge: accept the new word and → START. The line gets no idle gap and Busy stays 1.
  - DATA_VALID=0 at the STOP edge: → IDLE.
- DATA_VALID in START, DATA or PARITY is ignored. No queuing; the word is lost.
- The output mux is registered: TX_OUT is the flop output for the current state/bit, so the line never glitches.

## Timing
- Reset values (asynchronous, applied immediately): state=IDLE, TX_OUT=1, Busy=0, shift register=0, bit counter=0, latched parity config=0.
- Reset asserted mid-frame aborts the frame at once: TX_OUT=1 and Busy=0 in the same time step, with no clock needed.
- Accept at edge k gives:
  - TX_OUT=0 and Busy=1 from edge k.
  - Data bit i on TX_OUT from edge k+1+i.
  - Parity bit (when enabled) from edge k+1+DATA_LENGTH.
  - Stop bit on the last cycle of the frame.
- Frame length is 2+DATA_LENGTH+PAR_EN cycles: 11 with parity, 10 without at DATA_LENGTH=8.
- Busy falls at the edge that returns to IDLE, i.e. one frame length after the accept edge. It stays high across back-to-back frames.
- Minimum spacing between accepted words is one frame length. Sustained DATA_VALID=1 gives continuous frames with 100% line utilization.
- Latency from accept to first line activity (start bit) is 0 cycles after the accepting edge.

## Test plan
- Idle and reset:
  - Hold RST_TX=1 for 2 cycles, then release with DATA_VALID=0 for 5 cycles → TX_OUT=1 and Busy=0 throughout.
  - Assert RST_TX between edges → outputs return to reset values immediately.
- Even parity: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID.
  - TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1.
  - Busy high for exactly 11 cycles.
- Odd parity and no parity, both with P_DATA=8'hA5:
  - PAR_TYP=1 → parity bit = 1.
  - PAR_EN=0 → 10-cycle frame 0,1,0,1,0,0,1,0,1,1, then idle.
- Back-to-back: hold DATA_VALID=1, present 8'h55 then 8'hAA (changing P_DATA at the STOP cycle), even parity.
  - Two contiguous 11-bit frames with no idle cycle.
  - Busy stays 1 for 22 cycles.
- Ignored request: pulse DATA_VALID with 8'hFF during the DATA state of an 8'h00 frame.
  - Frame carries 8'h00 unchanged.
  - No second frame follows.
- Loopback: drive TX_OUT into the receiver (prescale 8, receive clock 8× faster), sending 20 random words across all PAR_EN/PAR_TYP combinations.
  - Received P_DATA equals sent data for every word.
  - data_valid pulses once per word.
  - parity_error=0 and stop_error=0 throughout.
